// File: rtl/stack_pkg.sv
// rtl/stack_pkg.sv - shared defaults and operation encoding for the data stack
package stack_pkg;

  localparam int STACK_WIDTH = 16;
  localparam int STACK_DEPTH = 16;

  // Encoding is {push, pop}
  typedef enum logic [1:0] {
    OP_HOLD    = 2'b00,
    OP_POP     = 2'b01,
    OP_PUSH    = 2'b10,
    OP_REPLACE = 2'b11
  } stack_op_e;

endpackage

// File: rtl/stack_regfile.sv
// rtl/stack_regfile.sv - DEPTH x WIDTH storage, one write port, two asynchronous read ports
module stack_regfile
  import stack_pkg::*;
#(
  parameter int WIDTH = STACK_WIDTH,
  parameter int DEPTH = STACK_DEPTH
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr_a,
  output logic [WIDTH-1:0]         rdata_a,
  input  logic [$clog2(DEPTH)-1:0] raddr_b,
  output logic [WIDTH-1:0]         rdata_b
);

  // Contents are deliberately left unreset; the stack masks stale entries.
  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata_a = mem[raddr_a];
  assign rdata_b = mem[raddr_b];

endmodule

// File: rtl/data_stack.sv
// rtl/data_stack.sv - LIFO operand stack with registered tos/nos and sticky error flags
module data_stack
  import stack_pkg::*;
#(
  parameter int WIDTH = STACK_WIDTH,
  parameter int DEPTH = STACK_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  input  logic                     clear_err,
  output logic [WIDTH-1:0]         tos,
  output logic [WIDTH-1:0]         nos,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  stack_op_e       op;
  logic [CW-1:0]   count_q, count_d;
  logic [WIDTH-1:0] tos_q, nos_q, tos_d, nos_d;
  logic [WIDTH-1:0] rdata_a, rdata_b;
  logic [AW-1:0]   waddr, raddr_a, raddr_b;
  logic            empty_q, full_q, overflow_q, underflow_q;
  logic            do_write, ovf_evt, unf_evt;

  assign op = stack_op_e'({push, pop});

  always_comb begin
    count_d  = count_q;
    do_write = 1'b0;
    waddr    = count_q[AW-1:0];
    ovf_evt  = 1'b0;
    unf_evt  = 1'b0;
    case (op)
      OP_PUSH: begin
        if (full_q) begin
          ovf_evt = 1'b1;
        end else begin
          count_d  = count_q + 1'b1;
          do_write = 1'b1;
        end
      end
      OP_POP: begin
        if (empty_q) unf_evt = 1'b1;
        else         count_d = count_q - 1'b1;
      end
      OP_REPLACE: begin
        if (empty_q) begin
          unf_evt = 1'b1;
        end else begin
          do_write = 1'b1;
          waddr    = AW'(count_q - 1'b1);
        end
      end
      default: ;
    endcase
  end

  // Reads look ahead at the post-operation pointer so tos/nos can be registered.
  // The slot being written this edge is only ever the new tos, which comes from din.
  assign raddr_a = AW'(count_d - 1'b1);
  assign raddr_b = AW'(count_d - CW'(2));

  always_comb begin
    tos_d = '0;
    nos_d = '0;
    if (do_write)            tos_d = din;
    else if (count_d != '0)  tos_d = rdata_a;
    if (count_d >= CW'(2))   nos_d = rdata_b;
  end

  stack_regfile #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_regfile (
    .clk     (clk),
    .we      (do_write),
    .waddr   (waddr),
    .wdata   (din),
    .raddr_a (raddr_a),
    .rdata_a (rdata_a),
    .raddr_b (raddr_b),
    .rdata_b (rdata_b)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q     <= '0;
      tos_q       <= '0;
      nos_q       <= '0;
      empty_q     <= 1'b1;
      full_q      <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      count_q     <= count_d;
      tos_q       <= tos_d;
      nos_q       <= nos_d;
      empty_q     <= (count_d == '0);
      full_q      <= (count_d == CW'(DEPTH));
      // A new error outranks a simultaneous clear
      overflow_q  <= ovf_evt | (overflow_q & ~clear_err);
      underflow_q <= unf_evt | (underflow_q & ~clear_err);
    end
  end

  assign tos       = tos_q;
  assign nos       = nos_q;
  assign count     = count_q;
  assign empty     = empty_q;
  assign full      = full_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

endmodule

// File: doc/data_stack.md
DATA_STACK -- requirements
Module: data_stack

Interface
REQ-001 Parameter WIDTH, default 16: data word width, matching the ALU operand mux input width.
REQ-002 Parameter DEPTH, default 16: number of stack entries; power of two, at least 4.
REQ-003 clk  input  1  single system clock; all state changes on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assertion, active-low.
REQ-005 push  input  1  push din onto the stack this cycle.
REQ-006 pop  input  1  pop the top entry this cycle.
REQ-007 din  input  WIDTH  data to push.
REQ-008 clear_err  input  1  clears the sticky error flags.
REQ-009 tos  output  WIDTH  top-of-stack, feeds an ALU operand mux input.
REQ-010 nos  output  WIDTH  next-of-stack, feeds an ALU operand mux input.
REQ-011 count  output  $clog2(DEPTH)+1  number of valid entries.
REQ-012 empty  output  1  high when count==0.
REQ-013 full  output  1  high when count==DEPTH.
REQ-014 overflow  output  1  sticky flag: a push was rejected.
REQ-015 underflow  output  1  sticky flag: a pop was rejected.

Function
REQ-016 Operation from {push,pop}: 00 hold; 10 push; 01 pop; 11 replace.
REQ-017 Push with count<DEPTH: din becomes tos, old tos becomes nos, count+1, all effective from the next cycle.
REQ-018 Pop with count>0: the entry below the top becomes tos, count-1, effective from the next cycle.
REQ-019 Replace with count>0: din overwrites tos, count unchanged, nos unchanged.
REQ-020 Replace with count==0: no state change; underflow set.
REQ-021 Push with full: no state change; din discarded; overflow set.
REQ-022 Pop with empty: no state change; underflow set.
REQ-023 tos is driven 0 whenever count==0.
REQ-024 nos is driven 0 whenever count<2.
REQ-025 tos, nos, count, empty and full are register-based: they are glitch-free and stable for the whole cycle after the edge that updated them.
REQ-026 Latency is one cycle: an operation at edge N is visible on the outputs after edge N.
REQ-027 clear_err clears both flags at the next edge.
REQ-028 If clear_err and a new error occur in the same cycle, the error wins and the flag stays set.
REQ-029 Stored data never wraps: the pointer saturates at 0 and DEPTH, and the rejected-operation rules above apply at both ends.

Reset
REQ-030 While rst_n is low: count=0, empty=1, full=0, overflow=0, underflow=0, tos=0, nos=0.
REQ-031 Reset asserted mid-operation discards the pending operation.
REQ-032 Storage array contents need not be reset; REQ-023 and REQ-024 mask stale data.
REQ-033 The first operation takes effect at the first rising clk edge after rst_n deasserts.

Structure
REQ-034 Shared package stack_pkg holds the WIDTH/DEPTH defaults and the 2-bit operation encoding (HOLD, PUSH, POP, REPLACE).
REQ-035 One sub-module, stack_regfile, SHALL be used: DEPTH x WIDTH, one write port, two asynchronous read ports (addresses sp-1 and sp-2).
REQ-036 The pointer, flag and output logic SHALL reside in data_stack.

Verification
REQ-037 Scenario: reset, then push 1,2,3 -> tos=3, nos=2, count=3, empty=0.
REQ-038 Scenario: from {1,2,3}, pop twice -> tos=1, nos=0, count=1; pop again -> empty=1, tos=0; pop again -> underflow=1, count=0.
REQ-039 Scenario: push 0..15 (DEPTH=16) -> full=1, tos=15; push 99 -> overflow=1, tos=15, count=16; pop -> tos=14, full=0.
REQ-040 Scenario: from {5,6}, push=pop=1 with din=0xABCD -> tos=0xABCD, nos=5, count=2; same operation on an empty stack -> underflow=1, count=0.
REQ-041 Scenario: with overflow=1, clear_err plus a simultaneous push while full -> overflow stays 1; clear_err alone -> overflow=0.
REQ-042 Scenario: assert rst_n low asynchronously between edges while count=4 -> outputs take reset values immediately; no push lands on the next edge.
